booth_mult_seq: RTL and testbench

- Parametrised, multi-cycle, radix-4 Booth multiplier with a start/done handshake.
- Successor to the 16-bit combinational Booth multiplier: generic WIDTH, signed or unsigned mode selectable per operation, and a registered product held until the next operation.
- Retires 2 multiplier bits per clock, trading latency for area, for use in datapaths that cannot afford a single-cycle WIDTH x WIDTH array.

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_r4_recode.sv | 20 ++
 rtl/booth_mult_seq.sv | 101 ++++++++++
 tb/tb_booth_mult_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

  // Operands are extended by 2 bits, so unsigned and signed modes share one iteration count.
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int acc_width(input int width);
    return width + 4;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: 3-bit multiplier window to signed digit select.
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output digit_t     digit
);

  always_comb begin
    digit = ZERO;
    case (win)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Multi-cycle radix-4 Booth multiplier, signed/unsigned per operation, start/done handshake.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N  = iter_count(WIDTH);
  localparam int EW = WIDTH + 2;
  localparam int AW = acc_width(WIDTH);
  localparam int CW = $clog2(N);

  state_t          state, state_nxt;
  logic            load;
  logic [EW-1:0]   m_q;
  logic [EW:0]     q_q;      // extended multiplier with the appended LSB below it
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;

  digit_t          digit;
  logic [AW-1:0]   m_sx, addend, acc_sum;
  logic [AW+EW:0]  shifted;
  logic [EW-1:0]   a_ext, b_ext;

  booth_r4_recode u_recode (.win(q_q[2:0]), .digit(digit));

  assign a_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
  assign b_ext = {{2{signed_mode & b[WIDTH-1]}}, b};

  always_comb begin
    m_sx   = {{(AW-EW){m_q[EW-1]}}, m_q};
    addend = '0;
    case (digit)
      POS1:    addend = m_sx;
      POS2:    addend = m_sx << 1;
      NEG1:    addend = -m_sx;
      NEG2:    addend = -(m_sx << 1);
      default: addend = '0;
    endcase
    acc_sum = acc_q + addend;
    shifted = $signed({acc_sum, q_q}) >>> 2;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = CALC;
      end
      CALC: if (cnt_q == '0) state_nxt = DONE;
      DONE: begin
        load      = start;
        state_nxt = start ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      p     <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        m_q   <= a_ext;
        q_q   <= {b_ext, 1'b0};
        acc_q <= '0;
        cnt_q <= CW'(N - 1);
      end else if (state == CALC) begin
        acc_q <= shifted[AW+EW:EW+1];
        q_q   <= shifted[EW:0];
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      // Product bits sit just above the appended LSB once every window has been retired.
      if (state == CALC && cnt_q == '0) p <= shifted[2*WIDTH:1];
    end
  end

  assign ready = (state != CALC);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: WIDTH=16 directed/random plus exhaustive WIDTH=4.
module tb_booth_mult_seq;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ready, busy, done;
  logic [31:0] p;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, busy4, done4;
  logic [7:0]  p4;

  int vecs = 0, errs = 0, accepts = 0, dones = 0;
  logic [31:0] sb[$];
  logic [7:0]  sb4[$];
  logic [31:0] last_p = '0, mon_exp;
  logic [7:0]  mon_exp4;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .p(p));

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .ready(ready4), .busy(busy4), .done(done4), .p(p4));

  function automatic logic [31:0] ref16(input logic sm, input logic [15:0] x, input logic [15:0] y);
    longint ex, ey;
    logic [63:0] pr;
    ex = sm ? longint'($signed(x)) : longint'(x);
    ey = sm ? longint'($signed(y)) : longint'(y);
    pr = 64'(ex * ey);
    return pr[31:0];
  endfunction

  function automatic logic [7:0] ref4(input logic sm, input logic [3:0] x, input logic [3:0] y);
    int ex, ey;
    logic [31:0] pr;
    ex = sm ? int'($signed(x)) : int'(x);
    ey = sm ? int'($signed(y)) : int'(y);
    pr = 32'(ex * ey);
    return pr[7:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL spurious_done16 got p=%h with nothing expected", p);
      end else begin
        mon_exp = sb.pop_front();
        last_p  = mon_exp;
        if (p !== mon_exp) begin
          errs++;
          $display("FAIL product16 got %h expected %h", p, mon_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      vecs++;
      if (sb4.size() == 0) begin
        errs++;
        $display("FAIL spurious_done4 got p=%h with nothing expected", p4);
      end else begin
        mon_exp4 = sb4.pop_front();
        if (p4 !== mon_exp4) begin
          errs++;
          $display("FAIL product4 got %h expected %h", p4, mon_exp4);
        end
      end
    end
  end

  task automatic start_op(input logic sm, input logic [15:0] x, input logic [15:0] y);
    signed_mode = sm; a = x; b = y; start = 1'b1;
    if (ready === 1'b1) begin
      sb.push_back(ref16(sm, x, y));
      accepts++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #1;
    vecs += 4;
    if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b expected 1", ready); end
    if (busy !== 1'b0)  begin errs++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (done !== 1'b0)  begin errs++; $display("FAIL reset_done got %b expected 0", done); end
    if (p !== 32'h0)    begin errs++; $display("FAIL reset_p got %h expected 0", p); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency;
    int n;
    logic bad;
    start_op(1'b1, 16'hFF82, 16'hFFFF);
    n = 1; bad = 1'b0;
    while (done !== 1'b1 && n < 50) begin
      if (ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    vecs += 3;
    if (bad) begin errs++; $display("FAIL calc_flags ready/busy wrong during CALC"); end
    if (n != 10) begin errs++; $display("FAIL latency got %0d edges expected 10", n); end
    if (p !== 32'h0000007E) begin errs++; $display("FAIL latency_p got %h expected 0000007e", p); end
    @(negedge clk);
  endtask

  task automatic test_corners;
    int n;
    logic        sm[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] xa[5] = '{16'h7FFF, 16'h8000, 16'd122, 16'hFFFF, 16'hFFFF};
    logic [15:0] xb[5] = '{16'h7FFF, 16'h8000, 16'h8939, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 5; i++) begin
      start_op(sm[i], xa[i], xb[i]);
      wait_done(n);
      vecs++;
      if (n >= 50) begin errs++; $display("FAIL corner_timeout case %0d", i); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    start_op(1'b0, 16'd3, 16'd7);
    wait_done(n);
    start_op(1'b1, 16'hFFFE, 16'd9);
    vecs += 2;
    if (busy !== 1'b1) begin errs++; $display("FAIL b2b_no_idle busy got %b expected 1", busy); end
    n = 1;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n != 10) begin errs++; $display("FAIL b2b_latency got %0d edges expected 10", n); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int n;
    logic [31:0] prev;
    prev = last_p;
    start_op(1'b1, 16'd1, 16'd1);
    @(negedge clk);
    start_op(1'b0, 16'd5, 16'd5);
    vecs++;
    if (p !== prev) begin errs++; $display("FAIL p_stable_calc got %h expected %h", p, prev); end
    wait_done(n);
    vecs++;
    if (n >= 50) begin errs++; $display("FAIL ignore_timeout"); end
    repeat (3) @(negedge clk);
    vecs++;
    if (p !== 32'h00000001) begin errs++; $display("FAIL ignore_hold got %h expected 00000001", p); end
  endtask

  task automatic test_reset_mid;
    int n;
    start_op(1'b1, 16'h1234, 16'h0F0F);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs += 4;
    if (ready !== 1'b1) begin errs++; $display("FAIL midrst_ready got %b expected 1", ready); end
    if (busy !== 1'b0)  begin errs++; $display("FAIL midrst_busy got %b expected 0", busy); end
    if (done !== 1'b0)  begin errs++; $display("FAIL midrst_done got %b expected 0", done); end
    if (p !== 32'h0)    begin errs++; $display("FAIL midrst_p got %h expected 0", p); end
    sb.delete();
    accepts--;
    last_p = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(1'b1, 16'hFFF9, 16'd300);
    wait_done(n);
    vecs++;
    if (n >= 50) begin errs++; $display("FAIL midrst_recover_timeout"); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int n;
    repeat (300) begin
      start_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      wait_done(n);
      if (n >= 50) begin vecs++; errs++; $display("FAIL random_timeout"); end
      @(negedge clk);
    end
  endtask

  task automatic test_exhaustive_w4;
    int n;
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          sm4 = 1'(s); a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
          sb4.push_back(ref4(1'(s), 4'(x), 4'(y)));
          @(negedge clk);
          start4 = 1'b0;
          n = 0;
          while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
          end
          if (n >= 20) begin vecs++; errs++; $display("FAIL w4_timeout a=%0d b=%0d", x, y); end
          @(negedge clk);
        end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_exhaustive_w4();
    repeat (4) @(negedge clk);
    vecs++;
    if (sb.size() != 0 || sb4.size() != 0 || dones != accepts) begin
      errs++;
      $display("FAIL done_count dones=%0d accepts=%0d pending=%0d/%0d", dones, accepts, sb.size(), sb4.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
